// File: rtl/l2_cacheline_adaptor_pkg.sv
// Shared types and default geometry for the L2 cacheline adaptor.
package l2_adaptor_types;

  localparam int unsigned LINE_W_DFLT  = 256;
  localparam int unsigned BURST_W_DFLT = 64;
  localparam int unsigned ADDR_W_DFLT  = 32;

  // Beats per line and line-offset bits for the default widths
  localparam int unsigned BEATS = LINE_W_DFLT / BURST_W_DFLT;
  localparam int unsigned OFS   = $clog2(LINE_W_DFLT / 8);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } adaptor_state_t;

endpackage

// File: rtl/l2_cacheline_adaptor.sv
// L2 cacheline adaptor: splits line writebacks into memory bursts and
// assembles fill bursts back into a line.
// Optional macro L2_ADAPTOR_PERF_CNT_EN adds saturating fill/writeback counters.
module l2_cacheline_adaptor
  import l2_adaptor_types::*;
#(
  parameter int unsigned LINE_W  = LINE_W_DFLT,
  parameter int unsigned BURST_W = BURST_W_DFLT,
  parameter int unsigned ADDR_W  = ADDR_W_DFLT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
`ifdef L2_ADAPTOR_PERF_CNT_EN
  ,
  output logic [31:0]        fill_cnt_o,
  output logic [31:0]        wb_cnt_o
`endif
);

  localparam int unsigned BEATS_N = LINE_W / BURST_W;
  localparam int unsigned OFS_N   = $clog2(LINE_W / 8);
  localparam int unsigned CNT_W   = (BEATS_N > 1) ? $clog2(BEATS_N) : 1;

  adaptor_state_t state_q, state_d;

  logic [CNT_W-1:0]                cnt_q;
  logic [ADDR_W-1:0]               addr_q;
  logic [BEATS_N-1:0][BURST_W-1:0] fill_q;
  logic [BEATS_N-1:0][BURST_W-1:0] wb_q;
  logic                            last_beat_c;

  assign last_beat_c = resp_i && (cnt_q == CNT_W'(BEATS_N - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; write wins over read when both are requested
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (write_i)     state_d = WRITE;
        else if (read_i) state_d = READ;
      end
      READ:    if (last_beat_c) state_d = DONE;
      WRITE:   if (last_beat_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latching, beat counter and fill-line assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      addr_q <= '0;
      fill_q <= '0;
      wb_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (write_i || read_i) begin
            cnt_q  <= '0;
            addr_q <= {address_i[ADDR_W-1:OFS_N], OFS_N'(0)};
          end
          if (write_i) wb_q <= line_i;
        end
        READ: begin
          if (resp_i) begin
            fill_q[cnt_q] <= burst_i;
            if (!last_beat_c) cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WRITE: begin
          if (resp_i && !last_beat_c) cnt_q <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Bus-side outputs decoded from the state register and latched data
  assign read_o    = (state_q == READ);
  assign write_o   = (state_q == WRITE);
  assign resp_o    = (state_q == DONE);
  assign address_o = addr_q;
  assign line_o    = fill_q;
  assign burst_o   = (state_q == WRITE) ? wb_q[cnt_q] : '0;

`ifdef L2_ADAPTOR_PERF_CNT_EN
  // Saturating completion counters, bumped on entry to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt_o <= '0;
      wb_cnt_o   <= '0;
    end else if (state_d == DONE) begin
      if (state_q == READ && fill_cnt_o != '1)  fill_cnt_o <= fill_cnt_o + 32'd1;
      if (state_q == WRITE && wb_cnt_o != '1)   wb_cnt_o   <= wb_cnt_o + 32'd1;
    end
  end
`endif

endmodule
